// File: rtl/uio_arb_pkg.sv
// Shared types and default sizing for the uio bus arbiter.
package uio_arb_pkg;

  localparam int NREQ_DEFAULT     = 3;
  localparam int MAX_HOLD_DEFAULT = 4;

  // IDLE: bus released, TURN: one dead cycle between owners, OWN: tenure active
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_OWN  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: requesters above the last owner come
// first, then the search wraps to bit 0, so the last owner itself is
// considered only after every other requester.
module rr_pick
  import uio_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] gnt,
  output logic            valid
);

  logic [NREQ-1:0] above_mask;
  logic [NREQ-1:0] req_above;
  logic [NREQ-1:0] pick_src;

  // Prefer requesters strictly above the last owner, else wrap around and isolate the lowest set bit
  always_comb begin
    above_mask = '0;
    for (int j = 0; j < NREQ; j++) begin
      above_mask[j] = (j > int'(last));
    end
    req_above = req & above_mask;
    pick_src  = (req_above != '0) ? req_above : req;
    gnt       = pick_src & (-pick_src);
    valid     = |req;
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Arbitrates NREQ requesters onto a shared 8-bit bidirectional uio bus with
// a one-cycle turnaround between owners and a bounded tenure when contended.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   wr_i,
  input  logic [8*NREQ-1:0] wdata_i,
  output logic [NREQ-1:0]   grant_o,
  output logic [7:0]        rdata_o,
  output logic              rvalid_o,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = $clog2(MAX_HOLD + 1);

  arb_state_t      state;
  logic [IDXW-1:0] owner_idx;
  logic            wr_lat;
  logic [CW-1:0]   hold_cnt;

  logic [NREQ-1:0] win_oh;
  logic            win_valid;
  logic [IDXW-1:0] win_idx;
  logic            win_wr;
  logic [NREQ-1:0] owner_oh;
  logic [7:0]      owner_wdata;
  logic            owner_req;
  logic            other_req;
  logic [CW-1:0]   hold_next;
  logic            hold_full;
  logic            own_active;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req   (req_i),
    .last  (owner_idx),
    .gnt   (win_oh),
    .valid (win_valid)
  );

  // Decode winner index/direction and the current owner's one-hot, data slice and request status
  always_comb begin
    win_idx     = '0;
    owner_oh    = '0;
    owner_wdata = 8'h00;
    for (int j = 0; j < NREQ; j++) begin
      if (win_oh[j]) begin
        win_idx = IDXW'(j);
      end
      owner_oh[j] = (int'(owner_idx) == j);
      owner_wdata = owner_wdata | (wdata_i[8*j +: 8] & {8{owner_oh[j]}});
    end
    win_wr    = |(wr_i & win_oh);
    owner_req = |(req_i & owner_oh);
    other_req = |(req_i & ~owner_oh);
  end

  // The hold count includes the current OWN cycle, so a contended tenure lasts exactly MAX_HOLD cycles
  always_comb begin
    hold_next = (hold_cnt == CW'(MAX_HOLD)) ? hold_cnt : hold_cnt + CW'(1);
    hold_full = (hold_next == CW'(MAX_HOLD));
  end

  // Bus drive and grant are gated by ena so dropping it releases the pads within the same cycle
  always_comb begin
    own_active = ena && (state == ST_OWN);
    grant_o    = own_active ? owner_oh : '0;
    uio_oe     = (own_active && wr_lat) ? 8'hFF : 8'h00;
    uio_out    = (own_active && wr_lat) ? owner_wdata : 8'h00;
  end

  // Arbitration FSM with tenure counter and registered read-data capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner_idx <= IDXW'(NREQ - 1);
      wr_lat    <= 1'b0;
      hold_cnt  <= '0;
      rdata_o   <= 8'h00;
      rvalid_o  <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      if (!ena) begin
        state    <= ST_IDLE;
        hold_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (win_valid) begin
              owner_idx <= win_idx;
              wr_lat    <= win_wr;
              state     <= ST_TURN;
            end
          end
          ST_TURN: begin
            hold_cnt <= '0;
            state    <= ST_OWN;
          end
          ST_OWN: begin
            hold_cnt <= hold_next;
            if (!wr_lat) begin
              rdata_o  <= uio_in;
              rvalid_o <= 1'b1;
            end
            if (!owner_req || (hold_full && other_req)) begin
              if (other_req) begin
                owner_idx <= win_idx;
                wr_lat    <= win_wr;
                state     <= ST_TURN;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed, table-driven bench for uio_bus_arbiter with NREQ=3, MAX_HOLD=4.
module tb_uio_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [2:0]  req_i;
  logic [2:0]  wr_i;
  logic [23:0] wdata_i;
  logic [2:0]  grant_o;
  logic [7:0]  rdata_o;
  logic        rvalid_o;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       ena;
    logic [2:0] req;
    logic [2:0] wr;
    logic [23:0] wdata;
    logic [7:0] uin;
    logic [2:0] grant;
    logic [7:0] oe;
    logic [7:0] out;
    logic [7:0] rdata;
    logic       rvalid;
  } vec_t;

  vec_t vecs[$];

  uio_bus_arbiter #(
    .NREQ     (3),
    .MAX_HOLD (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .req_i    (req_i),
    .wr_i     (wr_i),
    .wdata_i  (wdata_i),
    .grant_o  (grant_o),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o),
    .uio_in   (uio_in),
    .uio_out  (uio_out),
    .uio_oe   (uio_oe)
  );

  // Free-running 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(string nm, logic rs, logic en, logic [2:0] rq, logic [2:0] wr,
                              logic [23:0] wd, logic [7:0] ui, logic [2:0] g, logic [7:0] oe,
                              logic [7:0] out, logic [7:0] rd, logic rv);
    vec_t v;
    v.name = nm; v.rst_n = rs; v.ena = en; v.req = rq; v.wr = wr; v.wdata = wd; v.uin = ui;
    v.grant = g; v.oe = oe; v.out = out; v.rdata = rd; v.rvalid = rv;
    return v;
  endfunction

  // Drive inputs on the falling edge and let combinational outputs settle
  task automatic applyStimulus(input logic rs, input logic en, input logic [2:0] rq,
                               input logic [2:0] wr, input logic [23:0] wd, input logic [7:0] ui);
    @(negedge clk);
    rst_n   = rs;
    ena     = en;
    req_i   = rq;
    wr_i    = wr;
    wdata_i = wd;
    uio_in  = ui;
    #1;
  endtask

  task automatic compareField(input string nm, input string field, input logic [7:0] got,
                              input logic [7:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s.%s got=%h expected=%h at %0t", nm, field, got, exp, $time);
    end
  endtask

  task automatic checkOutput(input string nm, input logic [2:0] g, input logic [7:0] oe,
                             input logic [7:0] out, input logic [7:0] rd, input logic rv);
    compareField(nm, "grant_o", {5'b0, grant_o}, {5'b0, g});
    compareField(nm, "uio_oe", uio_oe, oe);
    compareField(nm, "uio_out", uio_out, out);
    compareField(nm, "rdata_o", rdata_o, rd);
    compareField(nm, "rvalid_o", {7'b0, rvalid_o}, {7'b0, rv});
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 24'h0, 8'h00);
    applyStimulus(1'b1, 1'b1, 3'b000, 3'b000, 24'h0, 8'h00);
    checkOutput("post_reset", 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  // Main sequence: table of single-cycle vectors, then contention and saturation sequences
  initial begin
    logic [2:0]  own_oh;
    logic [23:0] wd3;
    logic [7:0]  slice;
    int          owners[4];

    rst_n = 1'b0; ena = 1'b0; req_i = '0; wr_i = '0; wdata_i = '0; uio_in = '0;
    repeat (2) @(posedge clk);

    //             name           rst ena req     wr      wdata        uin    grant   oe     out    rdata  rv
    vecs.push_back(mk("reset",       0, 1, 3'b000, 3'b000, 24'h000000, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("idle_req",    1, 1, 3'b001, 3'b001, 24'h0000A5, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("turn_wr",     1, 1, 3'b001, 3'b001, 24'h0000A5, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("own_wr",      1, 1, 3'b001, 3'b001, 24'h0000A5, 8'h00, 3'b001, 8'hFF, 8'hA5, 8'h00, 0));
    vecs.push_back(mk("live_data",   1, 1, 3'b001, 3'b000, 24'h00005A, 8'h00, 3'b001, 8'hFF, 8'h5A, 8'h00, 0));
    vecs.push_back(mk("drop_req",    1, 1, 3'b000, 3'b000, 24'h00005A, 8'h00, 3'b001, 8'hFF, 8'h5A, 8'h00, 0));
    vecs.push_back(mk("idle_rd",     1, 1, 3'b010, 3'b000, 24'h000000, 8'h3C, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("turn_rd",     1, 1, 3'b010, 3'b000, 24'h000000, 8'h3C, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("own_rd",      1, 1, 3'b010, 3'b000, 24'h000000, 8'h3C, 3'b010, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("rvalid",      1, 1, 3'b000, 3'b000, 24'h000000, 8'h77, 3'b010, 8'h00, 8'h00, 8'h3C, 1));
    vecs.push_back(mk("last_sample", 1, 1, 3'b000, 3'b000, 24'h000000, 8'h77, 3'b000, 8'h00, 8'h00, 8'h77, 1));
    vecs.push_back(mk("rvalid_low",  1, 1, 3'b000, 3'b000, 24'h000000, 8'h77, 3'b000, 8'h00, 8'h00, 8'h77, 0));
    vecs.push_back(mk("idle_r2",     1, 1, 3'b100, 3'b100, 24'hC30000, 8'h00, 3'b000, 8'h00, 8'h00, 8'h77, 0));
    vecs.push_back(mk("turn_r2",     1, 1, 3'b100, 3'b100, 24'hC30000, 8'h00, 3'b000, 8'h00, 8'h00, 8'h77, 0));
    vecs.push_back(mk("own_r2",      1, 1, 3'b100, 3'b100, 24'hC30000, 8'h00, 3'b100, 8'hFF, 8'hC3, 8'h77, 0));
    vecs.push_back(mk("ena_low",     1, 0, 3'b100, 3'b100, 24'hC30000, 8'h00, 3'b000, 8'h00, 8'h00, 8'h77, 0));
    vecs.push_back(mk("ena_idle",    1, 1, 3'b100, 3'b100, 24'hC30000, 8'h00, 3'b000, 8'h00, 8'h00, 8'h77, 0));
    vecs.push_back(mk("ena_turn",    1, 1, 3'b100, 3'b100, 24'hC30000, 8'h00, 3'b000, 8'h00, 8'h00, 8'h77, 0));
    vecs.push_back(mk("ena_own",     1, 1, 3'b100, 3'b100, 24'hC30000, 8'h00, 3'b100, 8'hFF, 8'hC3, 8'h77, 0));
    vecs.push_back(mk("r2_drop",     1, 1, 3'b000, 3'b100, 24'hC30000, 8'h00, 3'b100, 8'hFF, 8'hC3, 8'h77, 0));
    vecs.push_back(mk("idle_r0",     1, 1, 3'b001, 3'b000, 24'h000000, 8'hE1, 3'b000, 8'h00, 8'h00, 8'h77, 0));
    vecs.push_back(mk("turn_r0",     1, 1, 3'b001, 3'b000, 24'h000000, 8'hE1, 3'b000, 8'h00, 8'h00, 8'h77, 0));
    vecs.push_back(mk("own_r0",      1, 1, 3'b001, 3'b000, 24'h000000, 8'hE1, 3'b001, 8'h00, 8'h00, 8'h77, 0));
    vecs.push_back(mk("rst_mid",     0, 1, 3'b001, 3'b000, 24'h000000, 8'h99, 3'b001, 8'h00, 8'h00, 8'hE1, 1));
    vecs.push_back(mk("after_rst",   1, 1, 3'b001, 3'b000, 24'h000000, 8'h99, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("rst_turn",    1, 1, 3'b001, 3'b000, 24'h000000, 8'h99, 3'b000, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("rst_own",     1, 1, 3'b001, 3'b000, 24'h000000, 8'h99, 3'b001, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("rst_sample",  1, 1, 3'b000, 3'b000, 24'h000000, 8'h99, 3'b001, 8'h00, 8'h00, 8'h99, 1));
    vecs.push_back(mk("rst_idle",    1, 1, 3'b000, 3'b000, 24'h000000, 8'h99, 3'b000, 8'h00, 8'h00, 8'h99, 1));
    vecs.push_back(mk("rst_quiet",   1, 1, 3'b000, 3'b000, 24'h000000, 8'h99, 3'b000, 8'h00, 8'h00, 8'h99, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].ena, vecs[i].req, vecs[i].wr, vecs[i].wdata, vecs[i].uin);
      checkOutput(vecs[i].name, vecs[i].grant, vecs[i].oe, vecs[i].out, vecs[i].rdata, vecs[i].rvalid);
    end

    // All three requesters held: 4-cycle tenures in order 0,1,2,0 with one TURN between
    $display("[TB] contention sequence");
    doReset();
    wd3 = 24'h332211;
    owners[0] = 0; owners[1] = 1; owners[2] = 2; owners[3] = 0;
    applyStimulus(1'b1, 1'b1, 3'b111, 3'b111, wd3, 8'h00);
    checkOutput("rr_idle", 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b111, 3'b111, wd3, 8'h00);
    checkOutput("rr_turn0", 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int t = 0; t < 4; t++) begin
      own_oh = 3'b001 << owners[t];
      slice  = 8'h11 * 8'(owners[t] + 1);
      for (int c = 0; c < 4; c++) begin
        applyStimulus(1'b1, 1'b1, 3'b111, 3'b111, wd3, 8'h00);
        checkOutput($sformatf("rr_own%0d_c%0d", t, c), own_oh, 8'hFF, slice, 8'h00, 1'b0);
      end
      applyStimulus(1'b1, 1'b1, 3'b111, 3'b111, wd3, 8'h00);
      checkOutput($sformatf("rr_turn%0d", t + 1), 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    end

    // Sole requester keeps the bus past MAX_HOLD; a late contender then takes over at once
    $display("[TB] sole requester sequence");
    doReset();
    applyStimulus(1'b1, 1'b1, 3'b010, 3'b010, 24'h005B00, 8'h00);
    checkOutput("sole_idle", 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b010, 3'b010, 24'h005B00, 8'h00);
    checkOutput("sole_turn", 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1'b1, 3'b010, 3'b010, 24'h005B00, 8'h00);
      checkOutput($sformatf("sole_own%0d", c), 3'b010, 8'hFF, 8'h5B, 8'h00, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 3'b011, 3'b010, 24'h005B00, 8'h00);
    checkOutput("sat_contend", 3'b010, 8'hFF, 8'h5B, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b011, 3'b010, 24'h005B00, 8'h00);
    checkOutput("sat_turn", 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b011, 3'b010, 24'h005B00, 8'h00);
    checkOutput("sat_new_owner", 3'b001, 8'h00, 8'h00, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
